// File: rtl/capture_sequencer.sv
// Sequences one acquisition run: flush the discriminator, enable buffer writes,
// stop on command/full/limit/timeout, drain the pipeline, then report the cause.
module capture_sequencer #(
  parameter int CHANNELS      = 8,
  parameter int FLUSH_CYCLES  = 4,
  parameter int DRAIN_CYCLES  = 66,
  parameter int COUNT_WIDTH   = 32,
  parameter int TIMEOUT_WIDTH = 32
) (
  input  logic                     adc_clk,
  input  logic                     adc_reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [COUNT_WIDTH-1:0]   cfg_sample_limit,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  input  logic                     cfg_full_all,
  input  logic [CHANNELS-1:0]      cfg_channel_mask,
  input  logic [CHANNELS-1:0]      disc_valid,
  input  logic [CHANNELS-1:0]      buf_full,
  output logic                     adc_reset_state,
  output logic                     adc_capture_enable,
  output logic [2:0]               status_state,
  output logic [COUNT_WIDTH-1:0]   status_sample_count,
  output logic                     done_valid,
  output logic [2:0]               done_cause
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FLUSH = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_ABORT = 2'd3;

  localparam logic [2:0] CAUSE_SW      = 3'd0;
  localparam logic [2:0] CAUSE_FULL    = 3'd1;
  localparam logic [2:0] CAUSE_LIMIT   = 3'd2;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd3;
  localparam logic [2:0] CAUSE_ABORT   = 3'd4;

  localparam int PW = $clog2(CHANNELS + 1);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  logic [2:0]               state_reg;
  logic                     ready_reg;
  logic [FW-1:0]            flush_cnt_reg;
  logic [DW-1:0]            drain_cnt_reg;
  logic [COUNT_WIDTH-1:0]   count_reg;
  logic [TIMEOUT_WIDTH-1:0] timer_reg;
  logic [COUNT_WIDTH-1:0]   limit_reg;
  logic [TIMEOUT_WIDTH-1:0] timeout_reg;
  logic [CHANNELS-1:0]      mask_reg;
  logic                     full_all_reg;
  logic                     done_valid_reg;
  logic [2:0]               done_cause_reg;

  logic [CHANNELS-1:0]    masked_valid;
  logic [CHANNELS-1:0]    masked_full;
  logic [PW-1:0]          valid_popcount;
  logic [COUNT_WIDTH:0]   count_sum;
  logic [COUNT_WIDTH-1:0] count_sat;
  logic                   counting;
  logic                   full_hit;
  logic                   limit_hit;
  logic                   timeout_hit;
  logic                   cmd_fire;
  logic                   op_start;
  logic                   op_stop;
  logic                   op_abort;
  logic                   run_start;

  assign masked_valid = disc_valid & mask_reg;
  assign masked_full  = buf_full & mask_reg;

  always_comb begin
    valid_popcount = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      valid_popcount = valid_popcount + PW'(masked_valid[i]);
    end
  end

  // Saturating accumulate; stop decisions look at the count including this cycle's samples.
  assign count_sum = {1'b0, count_reg} + (COUNT_WIDTH + 1)'(valid_popcount);
  assign count_sat = count_sum[COUNT_WIDTH] ? '1 : count_sum[COUNT_WIDTH-1:0];
  assign counting  = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);

  assign full_hit    = full_all_reg ? ((mask_reg != '0) && (masked_full == mask_reg))
                                    : (masked_full != '0);
  assign limit_hit   = (limit_reg != '0) && (count_sat >= limit_reg);
  assign timeout_hit = (timeout_reg != '0) && (timer_reg == timeout_reg - TIMEOUT_WIDTH'(1));

  assign cmd_ready = ready_reg && (state_reg != ST_FLUSH);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign op_start  = cmd_fire && (cmd_op == OP_START);
  assign op_stop   = cmd_fire && (cmd_op == OP_STOP);
  assign op_abort  = cmd_fire && (cmd_op == OP_ABORT);
  assign run_start = op_start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  always_ff @(posedge adc_clk) begin
    if (!adc_reset_n) begin
      state_reg      <= ST_IDLE;
      ready_reg      <= 1'b0;
      flush_cnt_reg  <= '0;
      drain_cnt_reg  <= '0;
      count_reg      <= '0;
      timer_reg      <= '0;
      limit_reg      <= '0;
      timeout_reg    <= '0;
      mask_reg       <= '0;
      full_all_reg   <= 1'b0;
      done_valid_reg <= 1'b0;
      done_cause_reg <= CAUSE_SW;
    end else begin
      ready_reg      <= 1'b1;
      done_valid_reg <= 1'b0;
      if (counting) begin
        count_reg <= count_sat;
      end
      if ((state_reg == ST_RUN) && (timer_reg != '1)) begin
        timer_reg <= timer_reg + TIMEOUT_WIDTH'(1);
      end

      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (op_stop) state_reg <= ST_IDLE;
        end
        ST_FLUSH: begin
          if (flush_cnt_reg == FLUSH_LAST) state_reg <= ST_RUN;
          else flush_cnt_reg <= flush_cnt_reg + FW'(1);
        end
        ST_RUN: begin
          drain_cnt_reg <= '0;
          if (op_abort) begin
            state_reg      <= ST_DONE;
            done_valid_reg <= 1'b1;
            done_cause_reg <= CAUSE_ABORT;
          end else if (op_stop) begin
            state_reg      <= ST_DRAIN;
            done_cause_reg <= CAUSE_SW;
          end else if (full_hit) begin
            state_reg      <= ST_DRAIN;
            done_cause_reg <= CAUSE_FULL;
          end else if (limit_hit) begin
            state_reg      <= ST_DRAIN;
            done_cause_reg <= CAUSE_LIMIT;
          end else if (timeout_hit) begin
            state_reg      <= ST_DRAIN;
            done_cause_reg <= CAUSE_TIMEOUT;
          end
        end
        ST_DRAIN: begin
          // A full buffer ends the drain early but keeps the original stop cause.
          if (op_abort) begin
            state_reg      <= ST_DONE;
            done_valid_reg <= 1'b1;
            done_cause_reg <= CAUSE_ABORT;
          end else if (full_hit || (drain_cnt_reg == DRAIN_LAST)) begin
            state_reg      <= ST_DONE;
            done_valid_reg <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + DW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (run_start) begin
        state_reg      <= ST_FLUSH;
        flush_cnt_reg  <= '0;
        count_reg      <= '0;
        timer_reg      <= '0;
        done_cause_reg <= CAUSE_SW;
        limit_reg      <= cfg_sample_limit;
        timeout_reg    <= cfg_timeout;
        mask_reg       <= cfg_channel_mask;
        full_all_reg   <= cfg_full_all;
      end
    end
  end

  assign status_state        = state_reg;
  assign adc_reset_state     = (state_reg == ST_IDLE) || (state_reg == ST_FLUSH);
  assign adc_capture_enable  = counting;
  assign status_sample_count = count_reg;
  assign done_valid          = done_valid_reg;
  assign done_cause          = done_cause_reg;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed and randomized checks of capture_sequencer against a run-level model
// that derives stop cycle, cause and final count from the stimulus arrays.
module tb_capture_sequencer;

  localparam int CH    = 8;
  localparam int DRAIN = 66;
  localparam int RMAX  = 128;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLUSH = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_ABORT = 2'd3;

  logic          adc_clk = 1'b0;
  logic          adc_reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = OP_NOP;
  logic [31:0]   cfg_sample_limit = '0;
  logic [31:0]   cfg_timeout = '0;
  logic          cfg_full_all = 1'b0;
  logic [CH-1:0] cfg_channel_mask = '0;
  logic [CH-1:0] disc_valid = '0;
  logic [CH-1:0] buf_full = '0;
  logic          adc_reset_state;
  logic          adc_capture_enable;
  logic [2:0]    status_state;
  logic [31:0]   status_sample_count;
  logic          done_valid;
  logic [2:0]    done_cause;

  capture_sequencer dut (
    .adc_clk             (adc_clk),
    .adc_reset_n         (adc_reset_n),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_op              (cmd_op),
    .cfg_sample_limit    (cfg_sample_limit),
    .cfg_timeout         (cfg_timeout),
    .cfg_full_all        (cfg_full_all),
    .cfg_channel_mask    (cfg_channel_mask),
    .disc_valid          (disc_valid),
    .buf_full            (buf_full),
    .adc_reset_state     (adc_reset_state),
    .adc_capture_enable  (adc_capture_enable),
    .status_state        (status_state),
    .status_sample_count (status_sample_count),
    .done_valid          (done_valid),
    .done_cause          (done_cause)
  );

  always #5 adc_clk = ~adc_clk;

  int checks = 0;
  int errors = 0;
  int pulse_seen = 0;
  int n;

  logic [CH-1:0] run_dv [RMAX];
  logic [CH-1:0] run_bf [RMAX];
  logic [CH-1:0] drn_dv [DRAIN];
  logic [CH-1:0] drn_bf [DRAIN];
  logic [CH-1:0] r_mask;
  logic          r_all;
  int r_limit, r_timeout, stop_k, abort_k;
  int exp_run, exp_drain, exp_cnt, exp_cause, k, j;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
    if (done_valid === 1'b1) pulse_seen++;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    cmd_op    = op;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic wait_leave(input logic [2:0] st, input int max, output int cnt);
    cnt = 0;
    while (status_state == st && cnt < max) begin
      tick();
      cnt++;
    end
  endtask

  task automatic configure(input int lim, input int tmo, input logic all, input logic [CH-1:0] msk);
    cfg_sample_limit = lim;
    cfg_timeout      = tmo;
    cfg_full_all     = all;
    cfg_channel_mask = msk;
  endtask

  function automatic bit full_rule(input logic [CH-1:0] bf, input logic [CH-1:0] msk, input logic all);
    if (all) return (msk != '0) && ((bf & msk) == msk);
    return (bf & msk) != '0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) tick();
    check("rst_state", 32'(status_state), 32'(S_IDLE));
    check("rst_reset_state", 32'(adc_reset_state), 32'd1);
    check("rst_enable", 32'(adc_capture_enable), 32'd0);
    check("rst_count", status_sample_count, 32'd0);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_cause", 32'(done_cause), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    adc_reset_n = 1'b1;
    tick();
    check("ready_after_release", 32'(cmd_ready), 32'd1);

    // Flush lasts 4 cycles, capture enable follows
    configure(0, 0, 1'b0, 8'hFF);
    send_cmd(OP_START);
    for (int i = 0; i < 4; i++) begin
      check("flush_state", 32'(status_state), 32'(S_FLUSH));
      check("flush_reset_state", 32'(adc_reset_state), 32'd1);
      check("flush_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    check("run_after_flush", 32'(status_state), 32'(S_RUN));
    check("run_enable", 32'(adc_capture_enable), 32'd1);
    check("run_reset_state", 32'(adc_reset_state), 32'd0);
    send_cmd(OP_ABORT);
    check("abort_run_state", 32'(status_state), 32'(S_DONE));
    check("abort_run_cause", 32'(done_cause), 32'd4);
    check("abort_run_enable", 32'(adc_capture_enable), 32'd0);

    // Sample limit: 4 samples/cycle, limit 100
    configure(100, 0, 1'b0, 8'h0F);
    disc_valid = 8'hFF;
    send_cmd(OP_START);
    wait_leave(S_FLUSH, 20, n);
    check("lim_flush_len", n, 4);
    wait_leave(S_RUN, 200, n);
    check("lim_run_len", n, 25);
    check("lim_drain_state", 32'(status_state), 32'(S_DRAIN));
    wait_leave(S_DRAIN, 200, n);
    check("lim_drain_len", n, 66);
    check("lim_done_state", 32'(status_state), 32'(S_DONE));
    check("lim_done_valid", 32'(done_valid), 32'd1);
    check("lim_cause", 32'(done_cause), 32'd2);
    check("lim_count", status_sample_count, 32'd364);
    disc_valid = '0;
    send_cmd(OP_STOP);
    check("done_stop_idle", 32'(status_state), 32'(S_IDLE));
    check("done_stop_reset_state", 32'(adc_reset_state), 32'd1);
    check("cause_held", 32'(done_cause), 32'd2);

    // Timeout 10, single done pulse
    configure(0, 10, 1'b0, 8'hFF);
    send_cmd(OP_START);
    pulse_seen = 0;
    wait_leave(S_FLUSH, 20, n);
    wait_leave(S_RUN, 200, n);
    check("tmo_run_len", n, 10);
    wait_leave(S_DRAIN, 200, n);
    check("tmo_drain_len", n, 66);
    check("tmo_cause", 32'(done_cause), 32'd3);
    check("tmo_done_valid", 32'(done_valid), 32'd1);
    repeat (3) tick();
    check("tmo_pulse_count", pulse_seen, 1);

    // Full-all with mask 0x03
    configure(0, 0, 1'b1, 8'h03);
    send_cmd(OP_START);
    wait_leave(S_FLUSH, 20, n);
    buf_full = 8'h01;
    repeat (5) tick();
    check("full_partial_run", 32'(status_state), 32'(S_RUN));
    buf_full = 8'h03;
    tick();
    check("full_all_drain", 32'(status_state), 32'(S_DRAIN));
    tick();
    check("full_in_drain_done", 32'(status_state), 32'(S_DONE));
    check("full_cause", 32'(done_cause), 32'd1);
    check("full_enable", 32'(adc_capture_enable), 32'd0);
    buf_full = '0;

    // Stop coincident with limit, then abort in drain
    configure(40, 0, 1'b0, 8'hFF);
    disc_valid = 8'hFF;
    send_cmd(OP_START);
    wait_leave(S_FLUSH, 20, n);
    repeat (4) tick();
    check("coinc_still_run", 32'(status_state), 32'(S_RUN));
    send_cmd(OP_STOP);
    check("coinc_drain", 32'(status_state), 32'(S_DRAIN));
    check("coinc_cause", 32'(done_cause), 32'd0);
    repeat (3) tick();
    send_cmd(OP_ABORT);
    check("drain_abort_state", 32'(status_state), 32'(S_DONE));
    check("drain_abort_cause", 32'(done_cause), 32'd4);
    check("drain_abort_valid", 32'(done_valid), 32'd1);

    // Reset in the middle of drain
    configure(0, 3, 1'b0, 8'hFF);
    send_cmd(OP_START);
    wait_leave(S_FLUSH, 20, n);
    wait_leave(S_RUN, 20, n);
    repeat (5) tick();
    check("pre_reset_drain", 32'(status_state), 32'(S_DRAIN));
    pulse_seen  = 0;
    adc_reset_n = 1'b0;
    tick();
    check("midrst_state", 32'(status_state), 32'(S_IDLE));
    check("midrst_reset_state", 32'(adc_reset_state), 32'd1);
    check("midrst_count", status_sample_count, 32'd0);
    check("midrst_enable", 32'(adc_capture_enable), 32'd0);
    adc_reset_n = 1'b1;
    disc_valid  = '0;
    repeat (3) tick();
    check("midrst_no_pulse", pulse_seen, 0);
    check("midrst_idle", 32'(status_state), 32'(S_IDLE));

    // Randomized runs against the run-level model
    for (int r = 0; r < 12; r++) begin
      r_mask    = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      r_all     = 1'($urandom % 2);
      r_limit   = ($urandom % 3 == 0) ? 0 : int'($urandom_range(1, 300));
      r_timeout = ($urandom % 3 == 0) ? 0 : int'($urandom_range(1, 100));
      stop_k    = ($urandom % 3 == 0) ? int'($urandom_range(0, 100)) : -1;
      abort_k   = ($urandom % 5 == 0) ? int'($urandom_range(0, 100)) : -1;
      if (r_timeout == 0 && stop_k < 0) stop_k = int'($urandom_range(0, 100));
      for (int i = 0; i < RMAX; i++) begin
        run_dv[i] = 8'($urandom);
        run_bf[i] = ($urandom % 30 == 0) ? 8'($urandom) : 8'h00;
      end
      for (int i = 0; i < DRAIN; i++) begin
        drn_dv[i] = 8'($urandom);
        drn_bf[i] = ($urandom % 40 == 0) ? 8'($urandom) : 8'h00;
      end

      exp_cnt = 0; exp_run = 0; exp_drain = 0; exp_cause = 7;
      for (int i = 0; i < RMAX; i++) begin
        exp_cnt += $countones(run_dv[i] & r_mask);
        exp_run = i + 1;
        if (i == abort_k) begin exp_cause = 4; break; end
        if (i == stop_k) begin exp_cause = 0; break; end
        if (full_rule(run_bf[i], r_mask, r_all)) begin exp_cause = 1; break; end
        if (r_limit != 0 && exp_cnt >= r_limit) begin exp_cause = 2; break; end
        if (r_timeout != 0 && i + 1 == r_timeout) begin exp_cause = 3; break; end
      end
      if (exp_cause != 4) begin
        for (int i = 0; i < DRAIN; i++) begin
          exp_cnt += $countones(drn_dv[i] & r_mask);
          exp_drain = i + 1;
          if (full_rule(drn_bf[i], r_mask, r_all)) break;
        end
      end

      configure(r_limit, r_timeout, r_all, r_mask);
      send_cmd(OP_START);
      wait_leave(S_FLUSH, 20, n);
      check("rnd_flush_len", n, 4);
      k = 0;
      while (status_state == S_RUN && k < RMAX) begin
        disc_valid = run_dv[k];
        buf_full   = run_bf[k];
        cmd_op     = OP_NOP;
        cmd_valid  = 1'b0;
        if (k == abort_k) begin
          cmd_valid = 1'b1; cmd_op = OP_ABORT;
        end else if (k == stop_k) begin
          cmd_valid = 1'b1; cmd_op = OP_STOP;
        end else if ($urandom % 6 == 0) begin
          cmd_valid = 1'b1; cmd_op = ($urandom % 2 == 1) ? OP_START : OP_NOP;
        end
        tick();
        k++;
      end
      j = 0;
      while (status_state == S_DRAIN && j < DRAIN + 4) begin
        disc_valid = drn_dv[j % DRAIN];
        buf_full   = drn_bf[j % DRAIN];
        cmd_valid  = ($urandom % 6 == 0);
        cmd_op     = 2'($urandom_range(0, 2));
        tick();
        j++;
      end
      cmd_valid  = 1'b0;
      cmd_op     = OP_NOP;
      disc_valid = '0;
      buf_full   = '0;
      $display("run %0d: mask=%02h all=%0d limit=%0d timeout=%0d stop_k=%0d abort_k=%0d -> run %0d/%0d drain %0d/%0d cause %0d/%0d count %0d/%0d",
               r, r_mask, r_all, r_limit, r_timeout, stop_k, abort_k, k, exp_run, j, exp_drain,
               done_cause, exp_cause, status_sample_count, exp_cnt);
      check("rnd_run_len", k, exp_run);
      check("rnd_drain_len", j, exp_drain);
      check("rnd_done_state", 32'(status_state), 32'(S_DONE));
      check("rnd_done_valid", 32'(done_valid), 32'd1);
      check("rnd_cause", 32'(done_cause), exp_cause);
      check("rnd_count", status_sample_count, exp_cnt);
      tick();
      check("rnd_pulse_end", 32'(done_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
